// File: rtl/fpn_pkg.sv
// fpn_pkg: shared constants and types for the fp_norm_pipe post-addition normaliser.
// The stage-1 payload struct is sized from the default widths held here.
package fpn_pkg;

    localparam int FPN_MW  = 24;                // significand width incl. hidden bit
    localparam int FPN_EW  = 8;                 // biased exponent width
    localparam int FPN_LZW = $clog2(FPN_MW);    // leading-zero count width

    // Which normalisation a beat needs.
    typedef enum logic [1:0] {
        NORM_CARRY,
        NORM_LEFT,
        NORM_ZERO
    } norm_case_e;

    // Everything stage 2 needs to finish the normalisation.
    typedef struct packed {
        logic               sign;
        logic [FPN_MW:0]    sig;
        logic [FPN_EW-1:0]  exp;
        norm_case_e         ncase;
        logic [FPN_LZW-1:0] lz;
    } fpn_s1_t;

endpackage

// File: rtl/fpn_lzc.sv
// fpn_lzc: combinational leading-zero counter with an all-zero flag.
module fpn_lzc #(
    parameter int W = 24
) (
    input  logic [W-1:0]         data_i,
    output logic [$clog2(W)-1:0] count_o,
    output logic                 zero_o
);

    localparam int CW = $clog2(W);

    // Scan upwards so the highest set bit sets the final count.
    always_comb begin
        // NOTE: outputs get a default first so no path through the block infers a latch.
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count_o = CW'(W - 1 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage post-addition normaliser with valid/ready back-pressure.
// Stage 1 classifies the beat and counts leading zeros; stage 2 shifts and adjusts the exponent.
// Build option FPN_DENORM_EN: gradual underflow to denormals; undefined, underflow flushes to zero.
module fp_norm_pipe
    import fpn_pkg::*;
#(
    parameter int MW = FPN_MW,
    parameter int EW = FPN_EW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [MW:0]   in_sig,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [MW-1:0] out_sig,
    output logic [EW-1:0] out_exp,
    output logic          out_lost,
    output logic          out_zero,
    output logic          out_ovf,
    output logic          out_unf
);

    localparam int LZW = $clog2(MW);
    localparam int XW  = EW + 2;               // signed exponent arithmetic width
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);

    logic           s1_valid_q;
    fpn_s1_t        s1_q, s1_d;
    logic           s2_valid_q;
    logic           s2_advance;
    logic [LZW-1:0] lz;
    logic           low_zero;

    // A stage may load when it is empty or its contents are moving on.
    assign s2_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_advance;

    fpn_lzc #(.W(MW)) u_lzc (
        .data_i  (in_sig[MW-1:0]),
        .count_o (lz),
        .zero_o  (low_zero)
    );

    // Classify the incoming beat and bundle it for stage 1.
    always_comb begin
        s1_d       = '0;
        s1_d.sign  = in_sign;
        s1_d.sig   = in_sig;
        s1_d.exp   = in_exp;
        s1_d.lz    = lz;
        if (in_sig[MW]) begin
            s1_d.ncase = NORM_CARRY;
        end else if (low_zero) begin
            s1_d.ncase = NORM_ZERO;
        end else begin
            s1_d.ncase = NORM_LEFT;
        end
    end

    // Stage-1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking (<=) so every register samples pre-edge values.
            s1_valid_q <= 1'b0;
            // NOTE: payload registers are reset as well, so a freshly reset pipe shows all-zero data.
            s1_q       <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    logic signed [XW-1:0] exp_x, lz_x, e_carry, e_left;
    logic [MW-1:0]        sig_d;
    logic [EW-1:0]        exp_d;
    logic                 lost_d, zero_d, ovf_d, unf_d;

    assign exp_x   = XW'(s1_q.exp);
    assign lz_x    = XW'(s1_q.lz);
    assign e_carry = exp_x + XW'(1);
    assign e_left  = exp_x - lz_x;

`ifdef FPN_DENORM_EN
    // Gradual underflow shifts only as far as the exponent allows, landing at exponent 0.
    logic [EW-1:0] dn_shift;
    logic [MW-1:0] dn_sig;
    assign dn_shift = (s1_q.exp == '0) ? '0 : s1_q.exp - EW'(1);
    assign dn_sig   = s1_q.sig[MW-1:0] << dn_shift;
`endif

    // Stage-2 shift, exponent adjust and flag generation.
    always_comb begin
        sig_d  = '0;
        exp_d  = '0;
        lost_d = 1'b0;
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        case (s1_q.ncase)
            NORM_CARRY: begin
                lost_d = s1_q.sig[0];
                if (e_carry >= EXP_MAX) begin
                    ovf_d = 1'b1;               // infinity: all-ones exponent, zero significand
                    exp_d = '1;
                end else begin
                    sig_d = s1_q.sig[MW:1];
                    exp_d = e_carry[EW-1:0];
                end
            end
            NORM_LEFT: begin
                if (!e_left[XW-1] && (e_left != '0)) begin
                    sig_d = s1_q.sig[MW-1:0] << s1_q.lz;
                    exp_d = e_left[EW-1:0];
                end else begin
                    unf_d = 1'b1;
`ifdef FPN_DENORM_EN
                    sig_d  = dn_sig;
                    zero_d = (dn_sig == '0);
`else
                    zero_d = 1'b1;
`endif
                end
            end
            default: begin
                zero_d = 1'b1;                  // NORM_ZERO
            end
        endcase
    end

    logic          sign_q, lost_q, zero_q, ovf_q, unf_q;
    logic [MW-1:0] sig_q;
    logic [EW-1:0] exp_q;

    // Stage-2 (output) register: holds steady while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sign_q     <= 1'b0;
            sig_q      <= '0;
            exp_q      <= '0;
            lost_q     <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sign_q <= s1_q.sign;
                sig_q  <= sig_d;
                exp_q  <= exp_d;
                lost_q <= lost_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = sign_q;
    assign out_sig   = sig_q;
    assign out_exp   = exp_q;
    assign out_lost  = lost_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb_fp_norm_pipe: directed and randomized checks of fp_norm_pipe against a reference model.
// Honours FPN_DENORM_EN the same way the design does.
module tb_fp_norm_pipe;

    localparam int MW = 24;
    localparam int EW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [MW:0]   in_sig;
    logic [EW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [MW-1:0] out_sig;
    logic [EW-1:0] out_exp;
    logic          out_lost;
    logic          out_zero;
    logic          out_ovf;
    logic          out_unf;

    fp_norm_pipe #(.MW(MW), .EW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_sig    (in_sig),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_sig   (out_sig),
        .out_exp   (out_exp),
        .out_lost  (out_lost),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          sign;
        logic [MW-1:0] sig;
        logic [EW-1:0] exp;
        logic          lost;
        logic          zero;
        logic          ovf;
        logic          unf;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_fifo[$];
    res_t exp_next;
    res_t out_now;

    assign out_now = '{out_sign, out_sig, out_exp, out_lost, out_zero, out_ovf, out_unf};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic res_t mk(input logic s, input logic [MW-1:0] sg, input logic [EW-1:0] ex,
                                input logic lost, input logic zero, input logic ovf, input logic unf);
        res_t r;
        r = '{s, sg, ex, lost, zero, ovf, unf};
        return r;
    endfunction

    // Reference: arithmetic straight from the normalisation rules.
    function automatic res_t model(input logic s, input logic [MW:0] v, input logic [EW-1:0] x);
        res_t r;
        int   e;
        int   lz;
        int   sh;
        r      = '0;
        r.sign = s;
        if (v == '0) begin
            r.zero = 1'b1;
        end else if (v >= 25'h1000000) begin
            r.lost = v[0];
            e      = int'(x) + 1;
            if (e >= 255) begin
                r.ovf = 1'b1;
                r.exp = 8'hFF;
            end else begin
                r.sig = 24'(v / 2);
                r.exp = 8'(e);
            end
        end else begin
            lz = 24 - $clog2(int'(v) + 1);
            e  = int'(x) - lz;
            if (e >= 1) begin
                r.sig = 24'(longint'(v) * (longint'(1) << lz));
                r.exp = 8'(e);
            end else begin
                r.unf = 1'b1;
`ifdef FPN_DENORM_EN
                sh     = (x > 0) ? int'(x) - 1 : 0;
                r.sig  = (sh >= 24) ? 24'd0 : 24'((longint'(v) * (longint'(1) << sh)) % (longint'(1) << 24));
                r.zero = (r.sig == 0);
`else
                sh     = 0;
                r.zero = 1'b1;
`endif
            end
        end
        return r;
    endfunction

    function automatic logic [MW:0] rand_sig();
        int          kind;
        logic [MW:0] v;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            v = '0;
        end else if (kind <= 3) begin
            v = {1'b1, 24'($urandom)};
        end else begin
            v = {1'b0, 24'($urandom) | 24'h800000};
            v = v >> $urandom_range(0, 23);
        end
        return v;
    endfunction

    function automatic logic [EW-1:0] rand_exp();
        int kind;
        kind = $urandom_range(0, 3);
        if (kind == 0) return 8'($urandom_range(0, 24));
        if (kind == 1) return 8'($urandom_range(248, 255));
        return 8'($urandom_range(0, 255));
    endfunction

    // Scoreboard: in-order result check, stall-stability check, and capture of accepted beats.
    logic stalled = 1'b0;
    res_t held;
    res_t want;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_fifo.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold", 64'({out_valid, out_now}), 64'({1'b1, held}));
            end
            if (out_valid && out_ready) begin
                if (exp_fifo.size() == 0) begin
                    check("extra_beat", 64'(exp_fifo.size()), 64'd1);
                end else begin
                    want = exp_fifo.pop_front();
                    check("beat", 64'(out_now), 64'(want));
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_now;
            if (in_valid && in_ready) begin
                exp_fifo.push_back(exp_next);
            end
        end
    end

    task automatic drive(input logic s, input logic [MW:0] v, input logic [EW-1:0] x, input res_t w);
        in_sign  = s;
        in_sig   = v;
        in_exp   = x;
        exp_next = w;
        in_valid = 1'b1;
    endtask

    // Present one beat and wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send(input logic s, input logic [MW:0] v, input logic [EW-1:0] x, input res_t w);
        int   n;
        logic acc;
        n = 0;
        drive(s, v, x, w);
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept one beat and confirm it appears exactly two edges later.
    task automatic latency_probe(input string tag, input logic [MW:0] v, input logic [EW-1:0] x, input res_t w);
        drive(1'b0, v, x, w);
        @(negedge clk);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_c1"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_c2"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [MW:0]   v;
        logic [EW-1:0] x;
        logic          s;
        logic          acc;
        int            k;
        int            n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_sig    = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        exp_next  = '0;

        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_now), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Already normalised, with latency probe.
        latency_probe("lat", 25'h0800000, 8'd127, mk(0, 24'h800000, 8'd127, 0, 0, 0, 0));

        // Directed cases, back to back.
        send(1'b0, 25'h1000001, 8'd127, mk(0, 24'h800000, 8'd128, 1, 0, 0, 0));
        send(1'b0, 25'h1000001, 8'd254, mk(0, 24'h000000, 8'hFF, 1, 0, 1, 0));
        send(1'b1, 25'h0000100, 8'd127, mk(1, 24'h800000, 8'd112, 0, 0, 0, 0));
        send(1'b0, 25'h0000000, 8'd90,  mk(0, 24'h000000, 8'd0, 0, 1, 0, 0));
`ifdef FPN_DENORM_EN
        send(1'b0, 25'h0000001, 8'd10,  mk(0, 24'h000200, 8'd0, 0, 0, 0, 1));
`else
        send(1'b0, 25'h0000001, 8'd10,  mk(0, 24'h000000, 8'd0, 0, 1, 0, 1));
`endif
        idle(4);

        // Back-pressure: four beats offered while the output stalls.
        k = 0;
        for (int c = 0; c < 9; c++) begin
            if (k < 4) begin
                if (!in_valid) begin
                    v = rand_sig();
                    x = rand_exp();
                    s = 1'($urandom);
                    drive(s, v, x, model(s, v, x));
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (c >= 5);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (c <= 1)           check("bp_rdy_open", 64'(in_ready), 64'd1);
            if (c >= 2 && c <= 4) check("bp_rdy_shut", 64'(in_ready), 64'd0);
            if (c >= 5)           check("bp_no_gap", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                in_valid = 1'b0;
            end
        end
        check("bp_all_in", 64'(k), 64'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Randomized traffic with random output stalls.
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    v = rand_sig();
                    x = rand_exp();
                    s = 1'($urandom);
                    drive(s, v, x, model(s, v, x));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_fifo.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        check("drain_empty", 64'(exp_fifo.size()), 64'd0);

        // Reset while two beats are held behind a stalled output.
        out_ready = 1'b0;
        v = rand_sig();
        x = rand_exp();
        send(1'b1, v, x, model(1'b1, v, x));
        v = rand_sig();
        x = rand_exp();
        send(1'b0, v, x, model(1'b0, v, x));
        @(negedge clk);
        check("stall_full", 64'({out_valid, in_ready}), 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_now), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        v = 25'h0012345;
        x = 8'd100;
        latency_probe("post_rst", v, x, model(1'b0, v, x));
        idle(3);
        check("final_empty", 64'(exp_fifo.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_pipe.md
# fp_norm_pipe

Two-stage pipelined, parametrised post-addition normaliser for the floating-point adder datapath. It sits between the significand adder/subtractor and the rounding stage.
- Accepts an unnormalised significand with carry bit, plus the pre-normalisation exponent and sign.
- Performs right-normalisation on carry or left-normalisation by leading-zero count.
- Adjusts the exponent and flags zero, overflow and underflow.
- Uses a valid/ready handshake with full back-pressure.

## Interface
Parameters:
- MW, 24: significand width including hidden bit.
- EW, 8: exponent width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_sign  in  1  sign, passed through.
- in_sig  in  MW+1  adder result; bit MW is the carry.
- in_exp  in  EW  biased exponent before normalisation.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  sign.
- out_sig  out  MW  normalised significand.
- out_exp  out  EW  adjusted biased exponent.
- out_lost  out  1  LSB discarded by the right shift (sticky input to the rounder).
- out_zero, out_ovf, out_unf  out  1 each  result flags.

## Operation
- A beat transfers when valid && ready on the same rising edge.
- Stage 1 registers the input and computes the normalisation case and shift count:
  - carry: in_sig[MW]=1.
  - left: carry clear, in_sig nonzero. Shift count lz = leading zeros of in_sig[MW-1:0], range 0..MW-1.
  - zero: in_sig all zero.
- Stage 2 applies the shift and the exponent arithmetic. Exponent math uses EW+2-bit signed width.
- carry case:
  - out_sig = in_sig[MW:1]; out_lost = in_sig[0]; e = in_exp+1.
  - If e ≥ 2^EW−1: out_ovf=1, out_exp all ones, out_sig=0 (infinity).
- left case:
  - e = in_exp − lz.
  - If e ≥ 1: out_sig = in_sig[MW-1:0] << lz; out_exp = e.
  - If e ≤ 0: underflow handling, see Configuration.
- zero case: out_zero=1, out_exp=0, out_sig=0, out_lost=0. No underflow or overflow flag.
- out_sign always equals the accepted in_sign.
- out_lost=0 for every case except carry.

## Timing
- Latency is 2 cycles. A beat accepted at edge N is valid in the cycle after edge N+1.
- Throughput is 1 beat/cycle while out_ready=1.
- Each stage advances when it is empty or the stage after it is advancing:
  - in_ready = !s1_valid || s2_advance.
  - s2_advance = !s2_valid || out_ready.
  - in_ready is combinational from out_ready.
- While out_valid=1 and out_ready=0, all out_* are held stable.
- At most 2 beats are held. No beat is dropped or duplicated, and order is preserved.
- Reset (asynchronous, at any time, including mid-stall): both stage valids clear, and out_valid=0.
  - All out_* data and flags reset to 0.
  - in_ready=1 while rst_n is high after reset.
  - Beats in flight at reset are discarded.

## Configuration
- FPN_DENORM_EN defined, when e ≤ 0:
  - Gradual underflow: shift by max(in_exp−1, 0) instead of lz.
  - out_exp=0; out_unf=1.
  - out_zero=1 only if the shifted significand is zero.
- FPN_DENORM_EN undefined, when e ≤ 0:
  - Flush to zero: out_sig=0, out_exp=0, out_unf=1, out_zero=1.

## Structure
- Package fpn_pkg holds:
  - default MW/EW constants.
  - the case enum {NORM_CARRY, NORM_LEFT, NORM_ZERO}.
  - the stage-1 payload struct (sign, sig, exp, case, lz).
- Sub-module fpn_lzc: parametrised combinational leading-zero counter, width MW, output $clog2(MW) bits plus an all-zero flag. Instantiated in stage 1.

## Test plan
All cases use MW=24, EW=8.
- Already normalised: in_sig=25'h0800000, exp=127 → out_sig=24'h800000, exp=127, no flags; out_valid exactly 2 cycles after acceptance.
- Carry: in_sig=25'h1000001, exp=127 → out_sig=24'h800000, exp=128, out_lost=1. Repeat with exp=254 → out_ovf=1, exp=8'hFF, sig=0.
- Left shift: in_sig=25'h0000100, exp=127 → lz=15, out_sig=24'h800000, exp=112.
- Zero and underflow:
  - in_sig=0, exp=90 → out_zero=1, exp=0, no other flags.
  - in_sig=25'h0000001, exp=10:
    - with FPN_DENORM_EN → out_sig=24'h000200, exp=0, unf=1.
    - without FPN_DENORM_EN → sig=0, exp=0, unf=1, zero=1.
- Back-pressure: 4 back-to-back beats with out_ready=0 for 3 cycles → in_ready drops after 2 beats, outputs held stable, and all 4 results emerge in order with no gaps once out_ready=1.
- Reset mid-stall: assert rst_n=0 with 2 beats held → out_valid=0 immediately and all outputs 0; after release the first new beat emerges with 2-cycle latency.
